// File: rtl/rr_pkg.sv
// ---------------------------------------------------------------------------
// rr_pkg
// Shared types and helpers for the round-robin arbiter.
//   rr_clog2  : index width for a requester count (minimum 1 bit)
//   rr_idx_t  : requester index type for the default 10-requester build
//   rr_inc    : modulo-n increment (wraps at n, not at a power of two)
//   rr_onehot : one-hot vector for an index, zero when the index is >= n
// ---------------------------------------------------------------------------
package rr_pkg;

    // Widest requester count the one-hot helper can represent.
    localparam int RR_NMAX = 64;

    function automatic int rr_clog2(int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int RR_N    = 10;
    localparam int RR_LOGN = rr_clog2(RR_N);

    typedef logic [RR_LOGN-1:0] rr_idx_t;

    function automatic int rr_inc(int idx, int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    function automatic logic [RR_NMAX-1:0] rr_onehot(int idx, int n);
        return (idx < n) ? (RR_NMAX'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_if
// Request/grant bundle between requesters and the round-robin arbiter.
//   en       : arbitration enable (requester side drives)
//   req      : per-requester pending request (requester side drives)
//   gnt      : registered one-hot-or-zero grant (arbiter drives)
//   gnt_vld  : registered, equals |gnt
//   gnt_idx  : registered binary index of the grant, 0 when idle
//   last_ptr : registered index of the most recently granted requester
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_arbiter_if #(
    parameter int N    = 10,
    parameter int LOGN = $clog2(N)
) ();
    logic            en;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic            gnt_vld;
    logic [LOGN-1:0] gnt_idx;
    logic [LOGN-1:0] last_ptr;

    modport master (
        output en, req,
        input  gnt, gnt_vld, gnt_idx, last_ptr
    );

    modport slave (
        input  en, req,
        output gnt, gnt_vld, gnt_idx, last_ptr
    );
endinterface

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational circular priority pick. Returns the lowest set bit of i_eff
// at or above i_start; if there is none, the lowest set bit overall (the
// search wraps past N-1 back to 0).
//   i_eff   : effective request vector
//   i_start : first index to consider (already wrapped into 0..N-1)
//   o_pick  : winning index, 0 when nothing is pending
//   o_any   : at least one bit of i_eff is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N    = 10,
    parameter int LOGN = $clog2(N)
) (
    input  logic [N-1:0]    i_eff,
    input  logic [LOGN-1:0] i_start,
    output logic [LOGN-1:0] o_pick,
    output logic            o_any
);

    logic            w_hi_any;
    logic [LOGN-1:0] w_hi_idx;
    logic            w_lo_any;
    logic [LOGN-1:0] w_lo_idx;

    // Two masked passes folded into one downward scan: the last hit written
    // is the lowest index, both for the "at or above start" pass and for the
    // unmasked wrap-around pass.
    always_comb begin
        w_hi_any = 1'b0;
        w_hi_idx = '0;
        w_lo_any = 1'b0;
        w_lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_eff[i]) begin
                w_lo_any = 1'b1;
                w_lo_idx = LOGN'(i);
                if (i >= int'(i_start)) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = LOGN'(i);
                end
            end
        end
    end

    assign o_pick = w_hi_any ? w_hi_idx : w_lo_idx;
    assign o_any  = w_lo_any;

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with registered one-hot grant. Each enabled cycle it
// grants the first pending requester strictly after last_ptr in circular
// order (mod N). A requester whose grant is currently showing is excluded,
// so grants are single-cycle pulses and a held request re-queues behind the
// others.
// Ports:
//   clk : clock
//   rst : synchronous, active-high reset (last_ptr -> N-1, grant cleared)
//   bus : rr_arbiter_if.slave (en, req in; gnt, gnt_vld, gnt_idx, last_ptr out)
// ---------------------------------------------------------------------------
module rr_arbiter
    import rr_pkg::*;
#(
    parameter int N    = 10,
    parameter int LOGN = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter_if.slave  bus
);

    logic [N-1:0]    r_gnt;
    logic            r_gnt_vld;
    logic [LOGN-1:0] r_gnt_idx;
    logic [LOGN-1:0] r_last_ptr;

    logic [N-1:0]    w_eff;
    logic [LOGN-1:0] w_start;
    logic [LOGN-1:0] w_pick;
    logic            w_any;
    logic [N-1:0]    w_pick_onehot;

    // The requester being granted right now is consumed this cycle.
    assign w_eff         = bus.req & ~r_gnt;
    assign w_start       = LOGN'(rr_inc(int'(r_last_ptr), N));
    assign w_pick_onehot = N'(rr_onehot(int'(w_pick), N));

    rr_pick #(
        .N    (N),
        .LOGN (LOGN)
    ) u_pick (
        .i_eff   (w_eff),
        .i_start (w_start),
        .o_pick  (w_pick),
        .o_any   (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt      <= '0;
            r_gnt_vld  <= 1'b0;
            r_gnt_idx  <= '0;
            r_last_ptr <= LOGN'(N - 1);
        end else if (bus.en && w_any) begin
            r_gnt      <= w_pick_onehot;
            r_gnt_vld  <= 1'b1;
            r_gnt_idx  <= w_pick;
            r_last_ptr <= w_pick;
        end else begin
            // Idle or stalled: any in-flight grant drops after its one cycle.
            r_gnt      <= '0;
            r_gnt_vld  <= 1'b0;
            r_gnt_idx  <= '0;
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.gnt_vld  = r_gnt_vld;
    assign bus.gnt_idx  = r_gnt_idx;
    assign bus.last_ptr = r_last_ptr;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(r_gnt));
    a_vld_matches : assert property (@(posedge clk) disable iff (rst)
        r_gnt_vld == (|r_gnt));
    a_idx_matches : assert property (@(posedge clk) disable iff (rst)
        r_gnt_vld |-> r_gnt[r_gnt_idx]);
    a_ptr_range   : assert property (@(posedge clk) disable iff (rst)
        int'(r_last_ptr) < N);

endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
// Directed bench for rr_arbiter: a 4-requester instance for the main
// scenarios and a 10-requester instance for the non-power-of-two wrap.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;

    logic clk;
    logic rst;

    int err_cnt = 0;
    int chk_cnt = 0;

    rr_arbiter_if #(.N(4))  bus4 ();
    rr_arbiter_if #(.N(10)) bus10 ();

    rr_arbiter #(.N(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    rr_arbiter #(.N(10)) u_dut10 (
        .clk (clk),
        .rst (rst),
        .bus (bus10)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [3:0] g, input logic [1:0] idx,
                          input logic vld, input logic [1:0] lp);
        check({tag, ".gnt"},      32'(bus4.gnt),      32'(g));
        check({tag, ".gnt_idx"},  32'(bus4.gnt_idx),  32'(idx));
        check({tag, ".gnt_vld"},  32'(bus4.gnt_vld),  32'(vld));
        check({tag, ".last_ptr"}, 32'(bus4.last_ptr), 32'(lp));
    endtask

    logic [3:0] full_seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0] full_idx [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        bus4.en    = 1'b0;
        bus4.req   = '0;
        bus10.en   = 1'b0;
        bus10.req  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check4("reset", 4'b0000, 2'd0, 1'b0, 2'd3);
        check("reset10.last_ptr", 32'(bus10.last_ptr), 32'd9);
        check("reset10.gnt",      32'(bus10.gnt),      32'd0);

        // Single request: granted the next cycle, then drops
        bus4.en  = 1'b1;
        bus4.req = 4'b0100;
        tick();
        check4("single.grant", 4'b0100, 2'd2, 1'b1, 2'd2);
        bus4.req = 4'b0000;
        tick();
        check4("single.drop", 4'b0000, 2'd0, 1'b0, 2'd2);

        // Full load after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check4("full.reset", 4'b0000, 2'd0, 1'b0, 2'd3);
        bus4.req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("full.gnt[%0d]", i), 32'(bus4.gnt), 32'(full_seq[i]));
            check($sformatf("full.idx[%0d]", i), 32'(bus4.gnt_idx), 32'(full_idx[i]));
            check($sformatf("full.onehot[%0d]", i), 32'($onehot(bus4.gnt)), 32'd1);
        end

        // Skip and wrap: last_ptr=1, requesters 3 and 0
        bus4.req = 4'b1001;
        tick();
        check4("wrap.first", 4'b1000, 2'd3, 1'b1, 2'd3);
        bus4.req = 4'b0001;
        tick();
        check4("wrap.second", 4'b0001, 2'd0, 1'b1, 2'd0);
        bus4.req = 4'b0000;

        // Stall: requests held, no grants, pointer frozen
        bus4.en  = 1'b0;
        bus4.req = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            check4($sformatf("stall[%0d]", i), 4'b0000, 2'd0, 1'b0, 2'd0);
        end
        bus4.en = 1'b1;
        tick();
        check4("stall.resume1", 4'b0010, 2'd1, 1'b1, 2'd1);
        bus4.req = 4'b0100;
        tick();
        check4("stall.resume2", 4'b0100, 2'd2, 1'b1, 2'd2);
        bus4.req = 4'b0000;
        tick();
        check4("stall.idle", 4'b0000, 2'd0, 1'b0, 2'd2);

        // Reset while a grant is showing
        bus4.req = 4'b0100;
        tick();
        check4("rstmid.pre", 4'b0100, 2'd2, 1'b1, 2'd2);
        rst      = 1'b1;
        bus4.req = 4'b0110;
        tick();
        check4("rstmid.reset", 4'b0000, 2'd0, 1'b0, 2'd3);
        check("rstmid10.last_ptr", 32'(bus10.last_ptr), 32'd9);
        rst = 1'b0;
        tick();
        check4("rstmid.first", 4'b0010, 2'd1, 1'b1, 2'd1);
        bus4.req = 4'b0100;
        tick();
        check4("rstmid.second", 4'b0100, 2'd2, 1'b1, 2'd2);
        bus4.req = 4'b0000;

        // N=10: wrap from 9 to 0, then 9
        bus10.en  = 1'b1;
        bus10.req = 10'b10_0000_0001;
        tick();
        check("n10.first.gnt", 32'(bus10.gnt),      32'h001);
        check("n10.first.idx", 32'(bus10.gnt_idx),  32'd0);
        check("n10.first.lp",  32'(bus10.last_ptr), 32'd0);
        bus10.req = 10'b10_0000_0000;
        tick();
        check("n10.second.gnt", 32'(bus10.gnt),      32'h200);
        check("n10.second.idx", 32'(bus10.gnt_idx),  32'd9);
        check("n10.second.lp",  32'(bus10.last_ptr), 32'd9);

        // N=10 full load from last_ptr=9: indices 0..9 then back to 0
        bus10.req = '1;
        for (int i = 0; i < 11; i++) begin
            tick();
            check($sformatf("n10.full.idx[%0d]", i), 32'(bus10.gnt_idx), 32'(i % 10));
            check($sformatf("n10.full.gnt[%0d]", i), 32'(bus10.gnt), 32'(1) << (i % 10));
            check($sformatf("n10.full.vld[%0d]", i), 32'(bus10.gnt_vld), 32'd1);
        end
        bus10.req = '0;
        tick();
        check("n10.idle.vld", 32'(bus10.gnt_vld),  32'd0);
        check("n10.idle.lp",  32'(bus10.last_ptr), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that produces the registered one-hot grant vector consumed by the round-robin protocol checker (b_rr_checker) and the downstream datapath mux.
- Keeps a pointer to the last granted requester. Each enabled cycle, it grants the first pending requester strictly after that pointer, in circular order.
- Guarantees onehot0(gnt), in-order service, and grant within N cycles of a request rising, provided en stays high.

Parameters:
- N, 10, number of requesters (N >= 2, need not be a power of 2)
- LOGN, $clog2(N), width of index fields

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  arbitration enable; 0 = stall, no new grant issued
- req  input  N  pending request per requester; held high until the cycle its gnt bit is seen
- gnt  output  N  registered one-hot-or-zero grant
- gnt_vld  output  1  registered; equals |gnt
- gnt_idx  output  LOGN  registered binary index of the granted bit; 0 when gnt_vld=0
- last_ptr  output  LOGN  registered index of the most recently granted requester

Behaviour:
- Reset (rst=1 at posedge): gnt=0, gnt_vld=0, gnt_idx=0, last_ptr=N-1, so req[0] has top priority after reset. rst has priority over everything, mid-grant included.
- Effective request: eff = req & ~gnt. A requester whose gnt bit is currently high is consumed this cycle and excluded. If its req is still high next cycle, that is a new request.
- Search order: last_ptr+1, last_ptr+2, ... wrapping modulo N (not modulo 2^LOGN). last_ptr itself is searched last.
- Next-state rules:
  - en=1 and eff!=0: gnt <= onehot(pick), gnt_idx <= pick, gnt_vld <= 1, last_ptr <= pick.
  - en=1 and eff==0: gnt <= 0, gnt_vld <= 0, gnt_idx <= 0, last_ptr unchanged.
  - en=0: gnt <= 0, gnt_vld <= 0, gnt_idx <= 0, last_ptr unchanged. The stall also drops an in-flight grant after its one cycle.
- Latency:
  - Earliest grant is the cycle after req rises (1 cycle).
  - Worst case is N cycles when all N request with en continuously 1.
- Grants are single-cycle pulses. The same requester is never granted in two consecutive cycles if any other requester is pending.
- Wrap-around:
  - last_ptr=N-1 -> search starts at 0.
  - Indices in the range N..2^LOGN-1 are never produced on gnt_idx or last_ptr.
- Simultaneous requests: only the single winner is granted. Non-winners stay pending and carry no penalty.
- Requests arriving during a stall are held by the requester and serviced in pointer order once en returns to 1.
- Internal invariants, checked with embedded assertions:
  - $onehot0(gnt)
  - gnt_vld == |gnt
  - gnt_vld -> gnt[gnt_idx]
  - last_ptr < N

Decomposition:
- Package rr_pkg holds:
  - the rr_idx_t typedef (logic [LOGN-1:0]), parameterised through a localparam function
  - function rr_inc(idx, n), returning modulo-n increment
  - function rr_onehot(idx, n)
- Sub-module rr_pick, purely combinational:
  - inputs: eff[N], start index (last_ptr+1 mod N)
  - outputs: pick index, any
  - method: double-width vector rotate plus priority encode, or a two-pass masked priority encoder
  - rr_arbiter instantiates it once and owns all state.
- b_rr_checker binds to rr_arbiter's req/gnt in formal runs.

Test Plan:
All scenarios use N=4 unless stated.
- Single request: rst, then req=0100 at cycle t -> gnt=0100, gnt_idx=2, gnt_vld=1 at t+1. Requester drops req at t+2 -> gnt=0000 at t+2, last_ptr=2.
- Full load: req=1111 held for 6 cycles after reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, 0010. Never two bits set.
- Skip and wrap: last_ptr=1, req=1001 -> gnt=1000, then 0001 (wraps past 3->0), last_ptr ends at 0.
- Stall: req=0110 with en=0 for 3 cycles -> gnt=0 and last_ptr unchanged. en=1 -> gnt=0010 next cycle, then 0100.
- Reset mid-operation: rst asserted while gnt=0100 -> next edge gnt=0, gnt_vld=0, last_ptr=3. Held req=0110 -> first grant after rst release is 0010.
- Non-power-of-2 wrap (N=10): last_ptr=9, req[0] and req[9] high -> grant 0 first, then 9. gnt_idx never exceeds 9. Run b_rr_checker formally with no failures.
